// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream bundle carrying the words drained from the FIFO.
// The master drives valid/data and the slave drives ready.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 8
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a sync_fifo (registered data_out) into a valid/ready stream.
// A 2-entry buffer hides the one-cycle read latency; flush drops buffered words.
module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_fifo_empty,
   input  logic [WIDTH-1:0]     i_fifo_data,
   output logic                 o_fifo_rd_en,
   input  logic                 i_flush,
   output logic [CNT_W-1:0]     o_word_cnt,
   fifo_stream_reader_if.master m_if
);

   logic [1:0]       r_cnt;
   logic             r_inflight;
   logic [WIDTH-1:0] r_buf0;
   logic [WIDTH-1:0] r_buf1;
   logic [CNT_W-1:0] r_word_cnt;

   logic [1:0]       w_cnt_next;
   logic             w_inflight_next;
   logic [WIDTH-1:0] w_buf0_next;
   logic [WIDTH-1:0] w_buf1_next;
   logic             w_pop;
   logic [1:0]       w_post_pop;
   logic [2:0]       w_occ;

   assign w_pop      = (r_cnt != 2'd0) & m_if.ready;
   assign w_post_pop = r_cnt - {1'b0, w_pop};
   // Occupancy after this edge if nothing is flushed: buffered + arriving - leaving.
   assign w_occ      = {1'b0, w_post_pop} + {2'b00, r_inflight};

   assign o_fifo_rd_en = ~i_rst & ~i_flush & ~i_fifo_empty & (w_occ < 3'd2);

   assign m_if.valid = (r_cnt != 2'd0);
   assign m_if.data  = r_buf0;
   assign o_word_cnt = r_word_cnt;

   always_comb begin
      w_cnt_next      = r_cnt;
      w_inflight_next = r_inflight;
      w_buf0_next     = r_buf0;
      w_buf1_next     = r_buf1;
      if (w_pop && (r_cnt == 2'd2)) begin
         w_buf0_next = r_buf1;
      end
      if (i_flush) begin
         w_cnt_next      = 2'd0;
         w_inflight_next = 1'b0;
      end else begin
         w_cnt_next      = w_occ[1:0];
         w_inflight_next = o_fifo_rd_en;
         if (r_inflight) begin
            if (w_post_pop == 2'd0) begin
               w_buf0_next = i_fifo_data;
            end else begin
               w_buf1_next = i_fifo_data;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= 2'd0;
         r_inflight <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
         r_word_cnt <= '0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_inflight <= w_inflight_next;
         r_buf0     <= w_buf0_next;
         r_buf1     <= w_buf1_next;
         if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
         end
      end
   end

   // The read strobe throttling must keep the buffer from ever overflowing.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_flush) begin
         assert (w_occ <= 3'd2);
      end
   end

endmodule
